execute_stage_fwd: RTL



---
 rtl/execute_stage_fwd_if.sv | 58 +++++
 rtl/execute_stage_fwd.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_fwd_if.sv
// Bundle of the execute stage's decode-side inputs, hazard controls and EX/MEM outputs.
// master: the decode/hazard side (drives E-side inputs, stall_i and flush_i).
// slave:  the execute stage (drives PCSrcE, PCTargetE, BusyE and the M-side register outputs).
// Parameters: XLEN datapath width, REG_AW register address width.
interface execute_stage_fwd_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              stall_i;
  logic              flush_i;
  logic              ValidE;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              BranchE;
  logic              JumpE;
  logic              JalrE;
  logic              ALUSrcE;
  logic [1:0]        ResultSrcE;
  logic [2:0]        BranchOpE;
  logic [3:0]        ALUControlE;
  logic [XLEN-1:0]   RD1_E;
  logic [XLEN-1:0]   RD2_E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [REG_AW-1:0] RD_E;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [XLEN-1:0]   ResultW;

  logic              PCSrcE;
  logic [XLEN-1:0]   PCTargetE;
  logic              BusyE;
  logic              ValidM;
  logic              RegWriteM;
  logic              MemWriteM;
  logic [1:0]        ResultSrcM;
  logic [REG_AW-1:0] RD_M;
  logic [XLEN-1:0]   PCPlus4M;
  logic [XLEN-1:0]   WriteDataM;
  logic [XLEN-1:0]   ALU_ResultM;

  modport master (
    output stall_i, flush_i, ValidE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
           ResultSrcE, BranchOpE, ALUControlE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, BusyE, ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );

  modport slave (
    input  stall_i, flush_i, ValidE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
           ResultSrcE, BranchOpE, ALUControlE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, BusyE, ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );
endinterface

// File: rtl/execute_stage_fwd.sv
// RV32I-style execute stage with operand forwarding, branch/jump resolution and an EX/MEM
// pipeline register with stall/flush/bubble control.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - execute_stage_fwd_if.slave: decode controls/operands, forward selects, stall_i,
//          flush_i, ResultW in; PCSrcE/PCTargetE redirect, BusyE, registered M-side fields out.
// Optional feature: define EXEC_MUL_EN to add an iterative 1-bit-per-cycle multiplier
// (ALUControlE = 11) that holds BusyE high for XLEN cycles. Without it, op 11 yields 0.
module execute_stage_fwd #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic                 clk,
  input logic                 rst,
  execute_stage_fwd_if.slave  bus
);
  localparam int unsigned ShW = $clog2(XLEN);

  logic [XLEN-1:0]   src_a, fwd_b, src_b;
  logic [XLEN-1:0]   alu_res, ex_res, jalr_sum;
  logic [ShW-1:0]    shamt;
  logic              taken;
  logic              busy;

  logic              valid_q, regwrite_q, memwrite_q;
  logic [1:0]        resultsrc_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   pcplus4_q, wdata_q, alu_result_q;

  // Operand forwarding; ALU_ResultM forwarding taps the local register.
  always_comb begin
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = bus.RD1_E;
    endcase
    case (bus.ForwardBE)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = bus.RD2_E;
    endcase
    src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;
  end

  assign shamt = src_b[ShW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.ALUControlE)
      4'd0:    alu_res = src_a + src_b;
      4'd1:    alu_res = src_a - src_b;
      4'd2:    alu_res = src_a & src_b;
      4'd3:    alu_res = src_a | src_b;
      4'd4:    alu_res = src_a ^ src_b;
      4'd5:    alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'd6:    alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'd7:    alu_res = src_a << shamt;
      4'd8:    alu_res = src_a >> shamt;
      4'd9:    alu_res = $signed(src_a) >>> shamt;
      4'd10:   alu_res = src_b;
      default: alu_res = '0;  // MUL is handled separately; 12-15 are reserved
    endcase
  end

  // Branch compare always uses the register operand, never the immediate.
  always_comb begin
    case (bus.BranchOpE)
      3'b000:  taken = (src_a == fwd_b);
      3'b001:  taken = (src_a != fwd_b);
      3'b100:  taken = ($signed(src_a) < $signed(fwd_b));
      3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  taken = (src_a < fwd_b);
      3'b111:  taken = (src_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum      = src_a + bus.ImmExtE;
  assign bus.PCSrcE    = bus.ValidE & ~bus.flush_i & (bus.JumpE | (bus.BranchE & taken));
  assign bus.PCTargetE = bus.JalrE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                                   : (bus.PCE + bus.ImmExtE);

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_st_e;

  mul_st_e         st_q, st_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d;
  logic [ShW-1:0]  mul_cnt_q, mul_cnt_d;
  logic            mul_issue;

  assign mul_issue = bus.ValidE & (bus.ALUControlE == 4'd11) & ~bus.flush_i;

  // The first shift-add step is folded into the issue edge so that BusyE spans exactly XLEN
  // cycles including the issue cycle; the counter then wraps back to 0 entering StDone.
  always_comb begin
    st_d      = st_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_acc_d = mul_acc_q;
    mul_cnt_d = mul_cnt_q;
    busy      = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (mul_issue) begin
          busy      = 1'b1;
          st_d      = StBusy;
          mul_acc_d = src_b[0] ? src_a : '0;
          mul_a_d   = src_a << 1;
          mul_b_d   = src_b >> 1;
          mul_cnt_d = ShW'(1);
        end
      end
      StBusy: begin
        busy      = 1'b1;
        mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
        mul_a_d   = mul_a_q << 1;
        mul_b_d   = mul_b_q >> 1;
        mul_cnt_d = mul_cnt_q + ShW'(1);
        if (mul_cnt_q == ShW'(XLEN - 1)) begin
          st_d = StDone;
        end
      end
      StDone: begin
        if (!bus.stall_i) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
    if (bus.flush_i) begin
      st_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= StIdle;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_acc_q <= '0;
      mul_cnt_q <= '0;
    end else begin
      st_q      <= st_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_acc_q <= mul_acc_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign ex_res = (bus.ALUControlE == 4'd11) ? mul_acc_q : alu_res;
`else
  assign busy   = 1'b0;
  assign ex_res = alu_res;
`endif

  assign bus.BusyE = busy;

  // EX/MEM register: flush beats stall; a busy multiplier inserts bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      resultsrc_q  <= '0;
      rd_q         <= '0;
      pcplus4_q    <= '0;
      wdata_q      <= '0;
      alu_result_q <= '0;
    end else if (bus.flush_i || (!bus.stall_i && busy)) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
    end else if (!bus.stall_i) begin
      valid_q      <= bus.ValidE;
      regwrite_q   <= bus.ValidE & bus.RegWriteE;
      memwrite_q   <= bus.ValidE & bus.MemWriteE;
      resultsrc_q  <= bus.ResultSrcE;
      rd_q         <= bus.RD_E;
      pcplus4_q    <= bus.PCPlus4E;
      wdata_q      <= fwd_b;
      alu_result_q <= ex_res;
    end
  end

  assign bus.ValidM      = valid_q;
  assign bus.RegWriteM   = regwrite_q;
  assign bus.MemWriteM   = memwrite_q;
  assign bus.ResultSrcM  = resultsrc_q;
  assign bus.RD_M        = rd_q;
  assign bus.PCPlus4M    = pcplus4_q;
  assign bus.WriteDataM  = wdata_q;
  assign bus.ALU_ResultM = alu_result_q;
endmodule
